// File: rtl/vga_pkg.sv
// VGA frame timing constants shared by v_counter and the vblank arbiter,
// plus the arbiter state type.
package vga_pkg;

  localparam int H_TOTAL_TIME    = 800;
  localparam int V_DISP_TIME     = 480;
  localparam int V_TOTAL_TIME    = 525;
  localparam int DEF_GUARD_LINES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    GRANT  = 2'd2,
    CLOSED = 2'd3
  } arb_state_t;

endpackage

// File: rtl/vblank_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or above rr_ptr, wrapping at N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // One extra bit of headroom so a non-power-of-2 N_REQ can wrap by subtraction.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_REQ)) begin
        sum = sum - (IW+1)'(N_REQ);
      end
      cand = sum[IW-1:0];
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vblank_arbiter.sv
// Round-robin framebuffer access grants confined to the vertical blanking window.
// Define VBLANK_ARB_TIMEOUT_EN to revoke grants held longer than MAX_GRANT_CYCLES.
module vblank_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int GUARD_LINES = DEF_GUARD_LINES
`ifdef VBLANK_ARB_TIMEOUT_EN
  ,
  parameter int MAX_GRANT_CYCLES = 4096
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_blank,
  input  logic [10:0]      v_cnt,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             window_open,
  output logic             overrun,
  output logic [2:0]       overrun_id
);

  localparam int            IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [10:0]   CLOSE_LINE = 11'(V_TOTAL_TIME - GUARD_LINES);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);

  arb_state_t       state, state_nxt;
  logic             v_blank_d;
  logic             rise, close_win;
  logic [N_REQ-1:0] gnt_nxt;
  logic             win_nxt, ovr_nxt;
  logic [2:0]       ovr_id_nxt;
  logic [IW-1:0]    rr_ptr, rr_nxt;
  logic [IW-1:0]    gnt_idx, gnt_idx_nxt;
  logic             pick_vld;
  logic [IW-1:0]    pick_idx;

  assign rise      = v_blank & ~v_blank_d;
  assign close_win = ~v_blank | (v_cnt >= CLOSE_LINE);

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .idx    (pick_idx)
  );

`ifdef VBLANK_ARB_TIMEOUT_EN
  localparam logic [12:0] HOLD_LAST = 13'(MAX_GRANT_CYCLES - 1);
  logic [12:0] hold_cnt;

  // Held at zero outside GRANT, so every new grant starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state != GRANT) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 13'd1;
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    win_nxt     = window_open;
    ovr_nxt     = 1'b0;
    ovr_id_nxt  = overrun_id;
    rr_nxt      = rr_ptr;
    gnt_idx_nxt = gnt_idx;
    case (state)
      IDLE: begin
        if (rise && !close_win) begin
          state_nxt = ARB;
          win_nxt   = 1'b1;
        end
      end
      ARB: begin
        if (close_win) begin
          state_nxt = CLOSED;
          win_nxt   = 1'b0;
        end else if (pick_vld) begin
          gnt_nxt           = '0;
          gnt_nxt[pick_idx] = 1'b1;
          gnt_idx_nxt       = pick_idx;
          rr_nxt            = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
          state_nxt         = GRANT;
        end
      end
      GRANT: begin
        // A release in the closing cycle is a clean hand-back, not an overrun.
        if (done[gnt_idx]) begin
          gnt_nxt   = '0;
          state_nxt = ARB;
        end else if (close_win) begin
          gnt_nxt    = '0;
          ovr_nxt    = 1'b1;
          ovr_id_nxt = 3'(gnt_idx);
          win_nxt    = 1'b0;
          state_nxt  = CLOSED;
        end
`ifdef VBLANK_ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          gnt_nxt    = '0;
          ovr_nxt    = 1'b1;
          ovr_id_nxt = 3'(gnt_idx);
          state_nxt  = ARB;
        end
`endif
      end
      CLOSED: begin
        gnt_nxt = '0;
        if (!v_blank) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      window_open <= 1'b0;
      overrun     <= 1'b0;
      overrun_id  <= '0;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      v_blank_d   <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      window_open <= win_nxt;
      overrun     <= ovr_nxt;
      overrun_id  <= ovr_id_nxt;
      rr_ptr      <= rr_nxt;
      gnt_idx     <= gnt_idx_nxt;
      v_blank_d   <= v_blank;
    end
  end

endmodule

// File: doc/vblank_arbiter.md
Name: vblank_arbiter

Overview:
- Schedules framebuffer/sprite-RAM update access among N_REQ requesters (game logic, board redraw, text overlay, ...) strictly inside the vertical blanking interval, so no tearing is visible.
- Sits beside v_counter: consumes v_blank/v_cnt, issues one-hot grants via a req/gnt/done handshake with round-robin fairness, and flags requesters still holding the resource when the window closes.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GUARD_LINES, 2, window closes when v_cnt >= V_TOTAL_TIME - GUARD_LINES (lines reserved before active video).

Ports:
- clk  input  1  pixel clock, same domain as v_counter.
- rst_n  input  1  asynchronous active-low reset.
- v_blank  input  1  vertical blank from v_counter.
- v_cnt  input  11  vertical line count from v_counter.
- req  input  N_REQ  per-requester access request, level.
- done  input  N_REQ  per-requester release pulse, valid only for granted index.
- gnt  output  N_REQ  one-hot grant, registered.
- window_open  output  1  high while grants may be issued.
- overrun  output  1  one-cycle pulse: grant forcibly revoked at window close.
- overrun_id  output  3  index of the revoked requester, held until next overrun.

Behaviour:
- Reset (async, rst_n low): state IDLE, gnt=0, window_open=0, overrun=0, overrun_id=0, rr_ptr=0, v_blank_d=0.
- Edge detect: v_blank_d registers v_blank; rise = v_blank & ~v_blank_d.
- close condition = ~v_blank | (v_cnt >= V_TOTAL_TIME - GUARD_LINES).
- States: IDLE, ARB, GRANT, CLOSED.
- IDLE: on rise & ~close -> ARB, window_open<=1. Rise with close true -> stay IDLE.
- ARB: if close -> CLOSED, window_open<=0. Else if |req: choose first set bit searching from rr_ptr upward with wrap; gnt<=onehot(idx), rr_ptr<=idx+1 mod N_REQ, -> GRANT. Else stay ARB.
- Latency: gnt asserted 2 cycles after the cycle v_blank first samples high (1 edge register + 1 ARB).
- GRANT: done[idx] for granted idx -> gnt<=0, -> ARB (even if close; done wins, no overrun). Else if close -> gnt<=0, overrun<=1 for 1 cycle, overrun_id<=idx, window_open<=0, -> CLOSED. req deassertion while granted is ignored; done for non-granted bits ignored.
- CLOSED: gnt=0; when ~v_blank -> IDLE. New rise only honoured from IDLE.
- Minimum 1 cycle with gnt=0 between consecutive grants (ARB cycle).
- Same requester may be regranted in one window; rr_ptr guarantees others first when asserting.
- rr_ptr persists across frames; not reset by window close.
- rr index arithmetic in $clog2(N_REQ) bits, wrap at N_REQ (non-power-of-2 handled explicitly).
- Reset mid-grant: gnt drops asynchronously, no overrun pulse.

Optional Feature:
- VBLANK_ARB_TIMEOUT_EN: adds parameter MAX_GRANT_CYCLES (default 4096) and 13-bit hold counter cleared on entry to GRANT. If counter reaches MAX_GRANT_CYCLES-1 without done -> revoke as overrun (pulse, overrun_id) but return to ARB if window still open.
- Without macro: a grant is held until done or window close only; no counter logic.

Decomposition:
- vga_pkg: add GUARD_LINES default constant and typedef enum arb_state_t {IDLE, ARB, GRANT, CLOSED}; reuse V_TOTAL_TIME.
- One sub-module: rr_pick (combinational round-robin priority select: req, rr_ptr -> valid, idx).

Test Plan:
- Reset: hold rst_n=0 mid-frame with req=4'b1111 -> gnt=0, window_open=0, overrun=0 asynchronously.
- Basic: v_blank rises, req=4'b0100 -> gnt=4'b0100 2 cycles later; done[2] pulse -> gnt=0 next cycle.
- Fairness: req=4'b1111 constant, each done after 3 cycles -> gnt order 0001,0010,0100,1000,0001, one idle cycle between.
- Overrun: grant req 1, no done, v_cnt reaches V_TOTAL_TIME-2 (GUARD_LINES=2) -> gnt=0, overrun 1-cycle pulse, overrun_id=1, window_open=0.
- Simultaneous: done[1] same cycle as close -> no overrun, state ends CLOSED, no new grant.
- Timeout (macro on, MAX_GRANT_CYCLES=16): req 0 never sends done -> revoked after 16 cycles, overrun_id=0, next requester granted in same window.
